// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the DataMem arbiter.
package data_mem_arb_pkg;

    localparam int NUM_PORTS = 2;
    localparam int STAT_W    = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester + DataMem bus bundle for the DataMem arbiter.
// slave = arbiter side, master = requesters/memory side.
interface data_mem_arbiter_if #(
    parameter int W = 8,
    parameter int A = 8
);
    logic         p0_req;
    logic         p0_we;
    logic [A-1:0] p0_addr;
    logic [W-1:0] p0_wdata;
    logic         p0_gnt;
    logic         p0_rvalid;
    logic [W-1:0] p0_rdata;

    logic         p1_req;
    logic         p1_we;
    logic [A-1:0] p1_addr;
    logic [W-1:0] p1_wdata;
    logic         p1_gnt;
    logic         p1_rvalid;
    logic [W-1:0] p1_rdata;

    logic         mem_WriteEn;
    logic [A-1:0] mem_DataAddress;
    logic [W-1:0] mem_DataIn;
    logic [W-1:0] mem_DataOut;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_DataOut,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_WriteEn, mem_DataAddress, mem_DataIn
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_DataOut,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_WriteEn, mem_DataAddress, mem_DataIn
    );

endinterface

// File: rtl/arb_rr_pick.sv
// Two-way round-robin pick: keeps the current owner until its burst is
// exhausted and the other port is waiting; from idle, ties go to the
// port that did not own the memory last.
module arb_rr_pick
    import data_mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 own_vld,    // an owner exists (not idle)
    input  logic                 owner,
    input  logic                 rr_last,
    input  logic                 burst_exh,
    output logic [NUM_PORTS-1:0] gnt,
    output logic                 win
);

    // Winner selection; at most one gnt bit, never without req
    always_comb begin
        gnt = '0;
        win = 1'b0;
        if (own_vld) begin
            if (req[owner] && (!burst_exh || !req[~owner])) begin
                win        = owner;
                gnt[owner] = 1'b1;
            end else if (req[~owner]) begin
                win         = ~owner;
                gnt[~owner] = 1'b1;
            end
        end else begin
            if (&req) begin
                win           = ~rr_last;
                gnt[~rr_last] = 1'b1;
            end else if (req[1]) begin
                win    = 1'b1;
                gnt[1] = 1'b1;
            end else if (req[0]) begin
                win    = 1'b0;
                gnt[0] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin, burst-bounded arbiter sharing a single-port DataMem between
// the core (port 0) and the DMA/init loader (port 1). Grants are
// combinational; read data returns registered one cycle after the grant.
// Optional: define ARB_STATS_EN for per-port saturating grant counters.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int W         = 8,
    parameter int A         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              Reset,
    data_mem_arbiter_if.slave bus,
    output logic [STAT_W-1:0] stat_gnt0,
    output logic [STAT_W-1:0] stat_gnt1
);

    localparam int             BCW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);

    logic [NUM_PORTS-1:0]        req, we;
    logic [NUM_PORTS-1:0][A-1:0] addr;
    logic [NUM_PORTS-1:0][W-1:0] wdata;
    logic [NUM_PORTS-1:0]        gnt;
    logic                        win;
    logic                        own_vld, owner, burst_exh;

    arb_state_t                  state_q, state_d;
    logic [BCW-1:0]              burst_cnt_q, burst_cnt_d;
    logic                        rr_last_q, rr_last_d;
    logic [NUM_PORTS-1:0]        rvalid_q, rvalid_d;
    logic [NUM_PORTS-1:0][W-1:0] rdata_q, rdata_d;
    logic [A-1:0]                addr_q, addr_d;
    logic [W-1:0]                wdata_q, wdata_d;

    // Requests are masked while reset is held so nothing is granted then
    assign req   = {bus.p1_req, bus.p0_req} & {NUM_PORTS{Reset}};
    assign we    = {bus.p1_we, bus.p0_we};
    assign addr  = {bus.p1_addr, bus.p0_addr};
    assign wdata = {bus.p1_wdata, bus.p0_wdata};

    assign own_vld   = (state_q != ARB_IDLE);
    assign owner     = (state_q == ARB_OWN1);
    assign burst_exh = (burst_cnt_q == BURST_LAST);

    arb_rr_pick u_pick (
        .req       (req),
        .own_vld   (own_vld),
        .owner     (owner),
        .rr_last   (rr_last_q),
        .burst_exh (burst_exh),
        .gnt       (gnt),
        .win       (win)
    );

    assign bus.p0_gnt = gnt[0];
    assign bus.p1_gnt = gnt[1];

    // Memory side: winner drives the bus; idle cycles hold the last beat
    assign bus.mem_WriteEn     = (|gnt) & we[win];
    assign bus.mem_DataAddress = (|gnt) ? addr[win]  : addr_q;
    assign bus.mem_DataIn      = (|gnt) ? wdata[win] : wdata_q;

    assign bus.p0_rvalid = rvalid_q[0];
    assign bus.p1_rvalid = rvalid_q[1];
    assign bus.p0_rdata  = rdata_q[0];
    assign bus.p1_rdata  = rdata_q[1];

    // Ownership/burst tracking, read return capture and bus hold values
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        rr_last_d   = rr_last_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rvalid_d    = gnt & ~we;
        rdata_d     = rdata_q;

        if (|gnt) begin
            addr_d  = addr[win];
            wdata_d = wdata[win];
            if (own_vld && (win == owner)) begin
                // saturate rather than wrap so a lone owner keeps streaming
                burst_cnt_d = burst_exh ? burst_cnt_q : burst_cnt_q + 1'b1;
            end else begin
                state_d     = win ? ARB_OWN1 : ARB_OWN0;
                burst_cnt_d = '0;
                rr_last_d   = win;
            end
        end else begin
            state_d     = ARB_IDLE;
            burst_cnt_d = '0;
        end

        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p] && !we[p]) rdata_d[p] = bus.mem_DataOut;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ARB_IDLE;
            burst_cnt_q <= '0;
            rr_last_q   <= 1'b1;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            rr_last_q   <= rr_last_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [NUM_PORTS-1:0][STAT_W-1:0] stat_q, stat_d;

    // Per-port granted-beat counters, saturating at all-ones
    always_comb begin
        stat_d = stat_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p] && (stat_q[p] != '1)) stat_d[p] = stat_q[p] + 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) stat_q <= '0;
        else        stat_q <= stat_d;
    end

    assign stat_gnt0 = stat_q[0];
    assign stat_gnt1 = stat_q[1];
`else
    assign stat_gnt0 = '0;
    assign stat_gnt1 = '0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter with a behavioural DataMem behind it.
// A negedge monitor keeps a reference memory and per-port read scoreboards.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] stat0, stat1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    data_mem_arbiter_if #(.W(8), .A(8)) bus ();

    data_mem_arbiter #(.W(8), .A(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .Reset     (rst_n),
        .bus       (bus),
        .stat_gnt0 (stat0),
        .stat_gnt1 (stat1)
    );

    // Behavioural DataMem: combinational read, clocked write
    logic [7:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    always @(posedge clk) if (bus.mem_WriteEn) mem[bus.mem_DataAddress] <= bus.mem_DataIn;
    assign bus.mem_DataOut = mem[bus.mem_DataAddress];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model and scoreboard
    logic [7:0] ref_mem [256];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [1:0] exp_rv = 2'b00;
    logic [7:0] last_addr = 8'h00;
    logic [7:0] last_din  = 8'h00;
    initial for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rvalid", {bus.p1_rvalid, bus.p0_rvalid}, 0);
            chk("rst_gnt", {bus.p1_gnt, bus.p0_gnt}, 0);
            chk("rst_we", bus.mem_WriteEn, 0);
            chk("rst_rdata", {bus.p1_rdata, bus.p0_rdata}, 0);
            exp_rv = 2'b00;
            q0.delete();
            q1.delete();
            last_addr = 8'h00;
            last_din  = 8'h00;
        end else begin
            chk("rvalid0", bus.p0_rvalid, exp_rv[0]);
            chk("rvalid1", bus.p1_rvalid, exp_rv[1]);
            if (bus.p0_rvalid) begin
                if (q0.size() > 0) chk("rdata0", bus.p0_rdata, q0.pop_front());
                else chk("sb_empty0", q0.size(), 1);
            end
            if (bus.p1_rvalid) begin
                if (q1.size() > 0) chk("rdata1", bus.p1_rdata, q1.pop_front());
                else chk("sb_empty1", q1.size(), 1);
            end
            chk("both_gnt", bus.p0_gnt & bus.p1_gnt, 0);
            chk("gnt_noreq", {bus.p1_gnt & ~bus.p1_req, bus.p0_gnt & ~bus.p0_req}, 0);
            if (bus.p0_gnt) begin
                chk("mem_addr0", bus.mem_DataAddress, bus.p0_addr);
                chk("mem_we0", bus.mem_WriteEn, bus.p0_we);
                chk("mem_din0", bus.mem_DataIn, bus.p0_wdata);
                if (bus.p0_we) ref_mem[bus.p0_addr] = bus.p0_wdata;
                else q0.push_back(ref_mem[bus.p0_addr]);
                last_addr = bus.p0_addr;
                last_din  = bus.p0_wdata;
            end else if (bus.p1_gnt) begin
                chk("mem_addr1", bus.mem_DataAddress, bus.p1_addr);
                chk("mem_we1", bus.mem_WriteEn, bus.p1_we);
                chk("mem_din1", bus.mem_DataIn, bus.p1_wdata);
                if (bus.p1_we) ref_mem[bus.p1_addr] = bus.p1_wdata;
                else q1.push_back(ref_mem[bus.p1_addr]);
                last_addr = bus.p1_addr;
                last_din  = bus.p1_wdata;
            end else begin
                chk("idle_we", bus.mem_WriteEn, 0);
                chk("hold_addr", bus.mem_DataAddress, last_addr);
                chk("hold_din", bus.mem_DataIn, last_din);
            end
            exp_rv = {bus.p1_gnt & ~bus.p1_we, bus.p0_gnt & ~bus.p0_we};
        end
    end

    function automatic logic gnt_of(input int p);
        return (p == 0) ? bus.p0_gnt : bus.p1_gnt;
    endfunction

    task automatic drive(input int p, input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin
            bus.p0_req = r; bus.p0_we = w; bus.p0_addr = a; bus.p0_wdata = d;
        end else begin
            bus.p1_req = r; bus.p1_we = w; bus.p1_addr = a; bus.p1_wdata = d;
        end
    endtask

    // One beat: hold the request until granted, return #1 after the grant edge
    task automatic beat(input int p, input logic w, input logic [7:0] a, input logic [7:0] d, output int waits);
        drive(p, 1'b1, w, a, d);
        waits = 0;
        @(negedge clk);
        while (!gnt_of(p) && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!gnt_of(p)) chk($sformatf("gnt_timeout_p%0d", p), gnt_of(p), 1);
        @(posedge clk);
        #1;
        drive(p, 1'b0, w, a, d);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int         w0, w1, w;
    logic [7:0] t2_exp [4];

    initial begin
        t2_exp = '{8'hBA, 8'hBB, 8'hB8, 8'hB9};
        drive(0, 1'b1, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b1, 1'b0, 8'h01, 8'h00);

        // 1: reset with both requesting, then p0 wins the first tie
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        fork
            beat(0, 1'b0, 8'h00, 8'h00, w0);
            beat(1, 1'b0, 8'h01, 8'h00, w1);
        join
        chk("t1_p0_first", w0, 0);
        chk("t1_p1_next", w1, 1);
        idle_cycle();

        // 2: p1 alone, back-to-back writes then reads
        for (int i = 0; i < 4; i++) begin
            beat(1, 1'b1, 8'h10 + 8'(i), (8'h10 + 8'(i)) ^ 8'hAA, w);
            chk("t2_wr_wait", w, 0);
        end
        for (int i = 0; i < 4; i++) begin
            beat(1, 1'b0, 8'h10 + 8'(i), 8'h00, w);
            chk("t2_rd_wait", w, 0);
            chk("t2_rvalid", bus.p1_rvalid, 1);
            chk("t2_rdata", bus.p1_rdata, t2_exp[i]);
        end
        idle_cycle();

        // 3: continuous contention, bursts of 4
        drive(0, 1'b1, 1'b0, 8'h30, 8'h00);
        drive(1, 1'b1, 1'b0, 8'h31, 8'h00);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("t3_gnt_%0d", i), {bus.p1_gnt, bus.p0_gnt}, ((i / 4) % 2 == 1) ? 2 : 1);
        end
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 8'h30, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h31, 8'h00);
        idle_cycle();

        // 4: read vs write to the same address in the same cycle
        beat(1, 1'b1, 8'h20, 8'h77, w);
        idle_cycle();
        fork
            begin
                beat(0, 1'b0, 8'h20, 8'h00, w0);
                chk("t4_old", bus.p0_rdata, 8'h77);
            end
            beat(1, 1'b1, 8'h20, 8'h55, w1);
        join
        chk("t4_p0_wins", w0, 0);
        chk("t4_p1_waits", w1, 1);
        idle_cycle();
        beat(0, 1'b0, 8'h20, 8'h00, w);
        chk("t4_new", bus.p0_rdata, 8'h55);
        idle_cycle();

        // 5: reset right after a read grant drops the pending rvalid
        beat(0, 1'b0, 8'h20, 8'h00, w);
        rst_n = 1'b0;
        #1 chk("t5_rvalid", bus.p0_rvalid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_idle_gnt", {bus.p1_gnt, bus.p0_gnt}, 0);
        idle_cycle();
        fork
            beat(0, 1'b0, 8'h40, 8'h00, w0);
            beat(1, 1'b0, 8'h41, 8'h00, w1);
        join
        chk("t5_p0_first", w0, 0);

        // 6: grant statistics
        do_reset();
        for (int i = 0; i < 300; i++) beat(0, 1'b1, 8'(i), 8'(i * 3), w);
        for (int i = 0; i < 10; i++) beat(1, 1'b1, 8'h80 + 8'(i), 8'(i), w);
        idle_cycle();
`ifdef ARB_STATS_EN
        chk("t6_stat0", stat0, 300);
        chk("t6_stat1", stat1, 10);
`else
        chk("t6_stat0", stat0, 0);
        chk("t6_stat1", stat1, 0);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
